// File: rtl/cfglut_n_if.sv
// cfglut_n_if: configuration shift chain and LUT read bundle for cfglut_n.
interface cfglut_n_if #(parameter int NB_IN = 5);
  logic ce;
  logic cdi;
  logic commit;
  logic [NB_IN-1:0] i;
  logic o;
  logic ol;
  logic cdo;
  logic [NB_IN:0] cfg_cnt;
  logic cfg_full;
  modport master(output ce, cdi, commit, i, input o, ol, cdo, cfg_cnt, cfg_full);
  modport slave(input ce, cdi, commit, i, output o, ol, cdo, cfg_cnt, cfg_full);
endinterface

// File: rtl/cfglut_n.sv
// cfglut_n: run-time reloadable LUT with serial config chain, optional shadow table and bit counter.
module cfglut_n #(
  parameter int NB_IN = 5,
  parameter logic [(1<<NB_IN)-1:0] INIT = '0,
  parameter bit IS_CLK_INVERTED = 1'b0,
  parameter bit SHADOW = 1'b0
) (
  input logic i_clk,
  input logic i_clr,
  cfglut_n_if.slave bus
);
  localparam int DEPTH = 1 << NB_IN;
  if (NB_IN < 2 || NB_IN > 6) begin : g_bad_nb_in
    $error("cfglut_n: NB_IN must be in 2..6");
  end
  logic w_clk;
  logic [DEPTH-1:0] r_t;
  logic [DEPTH-1:0] w_c;
  logic [NB_IN:0] r_cnt;
  assign w_clk = i_clk ^ IS_CLK_INVERTED;
  if (SHADOW) begin : g_shadow
    logic [DEPTH-1:0] r_s;
    always_ff @(posedge w_clk or posedge i_clr)
      if (i_clr) begin
        r_t <= INIT;
        r_s <= INIT;
      end else begin
        if (bus.commit) r_t <= r_s;
        if (bus.ce) r_s <= {r_s[DEPTH-2:0], bus.cdi};
      end
    assign w_c = r_s;
  end else begin : g_direct
    always_ff @(posedge w_clk or posedge i_clr)
      if (i_clr) r_t <= INIT;
      else if (bus.ce) r_t <= {r_t[DEPTH-2:0], bus.cdi};
    assign w_c = r_t;
  end
  // DEPTH is a power of two, so the counter MSB alone marks saturation
  always_ff @(posedge w_clk or posedge i_clr)
    if (i_clr) r_cnt <= '0;
    else if (bus.commit) r_cnt <= {{NB_IN{1'b0}}, bus.ce};
    else if (bus.ce && !r_cnt[NB_IN]) r_cnt <= r_cnt + (NB_IN+1)'(1);
  assign bus.o = r_t[bus.i];
  assign bus.ol = r_t[{1'b0, bus.i[NB_IN-2:0]}];
  assign bus.cdo = w_c[DEPTH-1];
  assign bus.cfg_cnt = r_cnt;
  assign bus.cfg_full = r_cnt[NB_IN];
endmodule

// File: tb/tb_cfglut_n.sv
// tb_cfglut_n: directed checks of reset, direct/shadow loading, CE gating, async clear and variants.
module tb_cfglut_n;
  logic clk = 1'b0;
  logic clr = 1'b0;
  logic ce = 1'b0, cdi = 1'b0, commit = 1'b0;
  logic ces = 1'b0, cdis = 1'b0, commits = 1'b0;
  logic ce2 = 1'b0, cdi2 = 1'b0;
  logic [4:0] a5 = '0;
  logic [5:0] a6 = '0;
  logic [1:0] a2 = '0;
  logic [31:0] v;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  cfglut_n_if #(.NB_IN(5)) ia();
  cfglut_n_if #(.NB_IN(5)) ib();
  cfglut_n_if #(.NB_IN(5)) ic();
  cfglut_n_if #(.NB_IN(6)) i6();
  cfglut_n_if #(.NB_IN(2)) i2();
  assign ia.ce = ce; assign ia.cdi = cdi; assign ia.commit = commit; assign ia.i = a5;
  assign ib.ce = ce; assign ib.cdi = cdi; assign ib.commit = commit; assign ib.i = a5;
  assign ic.ce = ces; assign ic.cdi = cdis; assign ic.commit = commits; assign ic.i = a5;
  assign i6.ce = 1'b0; assign i6.cdi = 1'b0; assign i6.commit = 1'b0; assign i6.i = a6;
  assign i2.ce = ce2; assign i2.cdi = cdi2; assign i2.commit = 1'b0; assign i2.i = a2;
  cfglut_n #(.NB_IN(5), .INIT(32'hDEADBEEF)) da(.i_clk(clk), .i_clr(clr), .bus(ia));
  cfglut_n #(.NB_IN(5), .INIT(32'h0)) db(.i_clk(clk), .i_clr(clr), .bus(ib));
  cfglut_n #(.NB_IN(5), .INIT(32'h0000FFFF), .SHADOW(1'b1)) dc(.i_clk(clk), .i_clr(clr), .bus(ic));
  cfglut_n #(.NB_IN(6), .INIT(64'h8000_0000_0000_0001)) d6(.i_clk(clk), .i_clr(clr), .bus(i6));
  cfglut_n #(.NB_IN(2), .INIT(4'b0110), .IS_CLK_INVERTED(1'b1)) d2(.i_clk(clk), .i_clr(clr), .bus(i2));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic e, input logic d, input logic c);
    @(negedge clk);
    ce = e; cdi = d; commit = c;
    @(posedge clk); #1;
    ce = 1'b0; commit = 1'b0;
  endtask
  task automatic cycs(input logic e, input logic d, input logic c);
    @(negedge clk);
    ces = e; cdis = d; commits = c;
    @(posedge clk); #1;
    ces = 1'b0; commits = 1'b0;
  endtask
  initial begin
    a5 = 5'b10001; a6 = 6'd63;
    #1 clr = 1'b1;
    #1 clr = 1'b0;
    #1;
    check("rst_o", ia.o, 0);
    check("rst_ol", ia.ol, 1);
    check("rst_cdo", ia.cdo, 1);
    check("rst_cnt", ia.cfg_cnt, 0);
    check("rst_full", ia.cfg_full, 0);
    check("w6_o63", i6.o, 1);
    check("w6_ol63", i6.ol, 0);
    a6 = 6'd0; #1;
    check("w6_o0", i6.o, 1);
    check("w6_ol0", i6.ol, 1);
    // inverted-clock narrow LUT: only falling edges shift
    @(negedge clk); #1 ce2 = 1'b1; cdi2 = 1'b1;
    @(posedge clk); #1;
    check("n2_no_rise_cnt", i2.cfg_cnt, 0);
    check("n2_no_rise_cdo", i2.cdo, 0);
    @(negedge clk); #1;
    check("n2_fall_cnt", i2.cfg_cnt, 1);
    check("n2_fall_cdo", i2.cdo, 1);
    cdi2 = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1 cdi2 = 1'b1;
    @(negedge clk); #1 ce2 = 1'b0;
    check("n2_cnt", i2.cfg_cnt, 4);
    check("n2_full", i2.cfg_full, 1);
    a2 = 2'd0; #1 check("n2_o0", i2.o, 1);
    a2 = 2'd1; #1 check("n2_o1", i2.o, 0);
    a2 = 2'd3; #1 check("n2_o3", i2.o, 1);
    check("n2_ol3", i2.ol, 0);
    // direct load into zero-init table
    v = 32'hDEADBEEF;
    for (int k = 31; k >= 0; k--) begin
      cyc(1'b1, v[k], 1'b0);
      if (k == 1) begin
        check("dl_cnt31", ib.cfg_cnt, 31);
        check("dl_full31", ib.cfg_full, 0);
      end
    end
    check("dl_cnt32", ib.cfg_cnt, 32);
    check("dl_full32", ib.cfg_full, 1);
    check("dl_cdo", ib.cdo, 1);
    a5 = 5'b10001; #1;
    check("dl_o17", ib.o, 0);
    check("dl_ol17", ib.ol, 1);
    a5 = 5'd0; #1;
    check("dl_o0", ib.o, 1);
    cyc(1'b1, 1'b0, 1'b0);
    check("dl_sat_cnt", ib.cfg_cnt, 32);
    check("dl_cdo33", ib.cdo, 1);
    cyc(1'b1, 1'b0, 1'b0);
    check("dl_cdo34", ib.cdo, 0);
    check("dl_o0_34", ib.o, 0);
    // partial load then asynchronous clear
    cyc(1'b0, 1'b0, 1'b1);
    check("cm_cnt0", ia.cfg_cnt, 0);
    v = 32'h0F0F0F0F;
    for (int k = 31; k >= 15; k--) cyc(1'b1, v[k], 1'b0);
    check("clr_pre_cnt", ia.cfg_cnt, 17);
    #2 clr = 1'b1;
    #1;
    check("clr_cnt", ia.cfg_cnt, 0);
    check("clr_o0", ia.o, 1);
    check("clr_cdo", ia.cdo, 1);
    clr = 1'b0;
    // gated reload with idle cycles
    for (int k = 31; k >= 0; k--) begin
      cyc(1'b1, v[k], 1'b0);
      if (k == 22) check("gate_cnt10", ib.cfg_cnt, 10);
      if (k % 3 == 0) cyc(1'b0, 1'b0, 1'b0);
    end
    check("gate_cnt", ib.cfg_cnt, 32);
    check("reload_cnt", ia.cfg_cnt, 32);
    check("reload_cdo", ia.cdo, 0);
    for (int j = 0; j < 32; j++) begin
      a5 = 5'(j); #1;
      check($sformatf("gate_t%0d", j), ib.o, v[j]);
    end
    a5 = 5'd4; #1 check("reload_o4", ia.o, 0);
    a5 = 5'd0; #1 check("reload_o0", ia.o, 1);
    // shadow table: active stays put until commit
    v = 32'h12345678;
    for (int k = 31; k >= 0; k--) begin
      cycs(1'b1, v[k], 1'b0);
      check("sh_hold_o0", ic.o, 1);
    end
    check("sh_cnt", ic.cfg_cnt, 32);
    check("sh_full", ic.cfg_full, 1);
    check("sh_cdo", ic.cdo, 0);
    cycs(1'b0, 1'b0, 1'b1);
    check("sh_cm_cnt", ic.cfg_cnt, 0);
    for (int j = 0; j < 32; j++) begin
      a5 = 5'(j); #1;
      check($sformatf("sh_t%0d", j), ic.o, v[j]);
    end
    cycs(1'b1, 1'b1, 1'b0);
    cycs(1'b1, 1'b0, 1'b0);
    cycs(1'b1, 1'b1, 1'b0);
    cycs(1'b1, 1'b1, 1'b0);
    a5 = 5'd0; #1;
    check("sh_pre_o0", ic.o, 0);
    check("sh_pre_cnt", ic.cfg_cnt, 4);
    cycs(1'b1, 1'b0, 1'b1);
    check("shc_cnt", ic.cfg_cnt, 1);
    check("shc_o0", ic.o, 1);
    a5 = 5'd2; #1 check("shc_o2", ic.o, 0);
    a5 = 5'd3; #1 check("shc_o3", ic.o, 1);
    check("shc_cdo", ic.cdo, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
